// File: rtl/eighteen_bit_serial_subtractor.sv
// Digit-serial subtractor: Output = SRC1 - SRC2, DIGIT bits per clock, LSB first.
// Optional signed saturation of Output when SERIAL_SUB_SAT_EN is defined.
module eighteen_bit_serial_subtractor #(
    parameter int WIDTH = 18,
    parameter int DIGIT = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] SRC1,
    input  logic [WIDTH-1:0] SRC2,
    input  logic             Start,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Output,
    output logic             Borrow,
    output logic             Zero,
    output logic             Negative,
    output logic             Overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;

    logic [DIGIT:0]       dsum;
    logic [WIDTH+DIGIT-1:0] cat;
    logic [WIDTH-1:0]     res_nxt;
    logic [WIDTH-1:0]     out_nxt;
    logic                 ov_nxt;
    logic                 last;

    // One digit of A + ~B + carry, and the result register after shifting it in at the MSB end
    always_comb begin
        dsum    = {1'b0, a_sh[DIGIT-1:0]}
                + {1'b0, ~b_sh[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, carry};
        cat     = {dsum[DIGIT-1:0], res};
        res_nxt = cat[WIDTH+DIGIT-1:DIGIT];
        ov_nxt  = (a_msb != b_msb) && (res_nxt[WIDTH-1] != a_msb);
        last    = (cnt == CW'(N - 1));
`ifdef SERIAL_SUB_SAT_EN
        // Clamp toward the sign of the minuend when the signed result overflowed
        if (ov_nxt) begin
            out_nxt = a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                            : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            out_nxt = res_nxt;
        end
`else
        out_nxt = res_nxt;
`endif
    end

    // Control FSM, datapath shift registers and registered result/flags
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            res      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Output   <= '0;
            Borrow   <= 1'b0;
            Zero     <= 1'b0;
            Negative <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (state == RUN) begin
                a_sh  <= a_sh >> DIGIT;
                b_sh  <= b_sh >> DIGIT;
                res   <= res_nxt;
                carry <= dsum[DIGIT];
                cnt   <= cnt + CW'(1);
                if (last) begin
                    state    <= DONE;
                    Busy     <= 1'b0;
                    Done     <= 1'b1;
                    Output   <= out_nxt;
                    Borrow   <= ~dsum[DIGIT];
                    Zero     <= (out_nxt == '0);
                    Negative <= out_nxt[WIDTH-1];
                    Overflow <= ov_nxt;
                end
            end else if (Start) begin
                // Accepted from IDLE or back-to-back from DONE
                state <= RUN;
                a_sh  <= SRC1;
                b_sh  <= SRC2;
                a_msb <= SRC1[WIDTH-1];
                b_msb <= SRC2[WIDTH-1];
                res   <= '0;
                carry <= 1'b1;
                cnt   <= '0;
                Busy  <= 1'b1;
            end else begin
                state <= IDLE;
            end
        end
    end

endmodule
